// File: rtl/bp_cfg_sequencer.sv
// Boot-time configuration master: walks every tile of the core-complex mesh writing
// freeze/id/coordinate registers, fences, then unfreezes every tile under a credit limit.
module bp_cfg_sequencer #(
  parameter int cc_x_dim_p        = 2,
  parameter int cc_y_dim_p        = 2,
  parameter int cfg_addr_width_p  = 16,
  parameter int cfg_data_width_p  = 64,
  parameter int max_outstanding_p = 4,
  parameter int x_cord_width_p    = (cc_x_dim_p > 1) ? $clog2(cc_x_dim_p) : 1,
  parameter int y_cord_width_p    = (cc_y_dim_p > 1) ? $clog2(cc_y_dim_p) : 1
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        start_i,
  output logic                        cfg_v_o,
  input  logic                        cfg_ready_i,
  output logic [x_cord_width_p-1:0]   cfg_x_o,
  output logic [y_cord_width_p-1:0]   cfg_y_o,
  output logic [cfg_addr_width_p-1:0] cfg_addr_o,
  output logic [cfg_data_width_p-1:0] cfg_data_o,
  input  logic                        ack_v_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        err_o
);

  localparam int cnt_width_lp = $clog2(max_outstanding_p + 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CFG      = 3'd1,
    FENCE    = 3'd2,
    UNFREEZE = 3'd3,
    DRAIN    = 3'd4,
    DONE     = 3'd5
  } state_e;

  state_e                      state_reg, state_next;
  logic [x_cord_width_p-1:0]   x_reg, x_next;
  logic [y_cord_width_p-1:0]   y_reg, y_next;
  logic [1:0]                  idx_reg, idx_next;
  logic [cnt_width_lp-1:0]     outstanding_reg, outstanding_next;
  logic                        err_reg, err_next;
  logic [cfg_addr_width_p-1:0] addr_reg, addr_next;
  logic [cfg_data_width_p-1:0] data_reg, data_next;

  logic issue_en;
  logic handshake;
  logic last_x, last_y;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_reg       <= IDLE;
      x_reg           <= '0;
      y_reg           <= '0;
      idx_reg         <= '0;
      outstanding_reg <= '0;
      err_reg         <= 1'b0;
      addr_reg        <= '0;
      data_reg        <= '0;
    end else begin
      state_reg       <= state_next;
      x_reg           <= x_next;
      y_reg           <= y_next;
      idx_reg         <= idx_next;
      outstanding_reg <= outstanding_next;
      err_reg         <= err_next;
      addr_reg        <= addr_next;
      data_reg        <= data_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    x_next           = x_reg;
    y_next           = y_reg;
    idx_next         = idx_reg;
    outstanding_next = outstanding_reg;
    err_next         = err_reg;
    addr_next        = '0;
    data_next        = '0;

    issue_en  = ((state_reg == CFG) || (state_reg == UNFREEZE)) &&
                (outstanding_reg < cnt_width_lp'(max_outstanding_p));
    handshake = issue_en & cfg_ready_i;
    last_x    = (x_reg == x_cord_width_p'(cc_x_dim_p - 1));
    last_y    = (y_reg == y_cord_width_p'(cc_y_dim_p - 1));

    case (state_reg)
      IDLE, DONE: begin
        if (start_i) begin
          state_next = CFG;
          x_next     = '0;
          y_next     = '0;
          idx_next   = '0;
          if (state_reg == DONE) err_next = 1'b0;
        end
      end
      CFG: begin
        if (handshake) begin
          if (idx_reg != 2'd2) begin
            idx_next = idx_reg + 2'd1;
          end else begin
            idx_next = '0;
            if (!last_x) begin
              x_next = x_reg + x_cord_width_p'(1);
            end else begin
              x_next = '0;
              if (!last_y) begin
                y_next = y_reg + y_cord_width_p'(1);
              end else begin
                y_next     = '0;
                state_next = FENCE;
              end
            end
          end
        end
      end
      FENCE: begin
        if (outstanding_reg == '0) begin
          state_next = UNFREEZE;
          x_next     = '0;
          y_next     = '0;
        end
      end
      UNFREEZE: begin
        if (handshake) begin
          if (!last_x) begin
            x_next = x_reg + x_cord_width_p'(1);
          end else begin
            x_next = '0;
            if (!last_y) begin
              y_next = y_reg + y_cord_width_p'(1);
            end else begin
              y_next     = '0;
              state_next = DRAIN;
            end
          end
        end
      end
      DRAIN: begin
        if (outstanding_reg == '0) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase

    // An ack with nothing outstanding is a protocol error; the counter must not wrap.
    case ({handshake, ack_v_i})
      2'b10: outstanding_next = outstanding_reg + cnt_width_lp'(1);
      2'b01: begin
        if (outstanding_reg == '0) err_next = 1'b1;
        else outstanding_next = outstanding_reg - cnt_width_lp'(1);
      end
      default: outstanding_next = outstanding_reg;
    endcase

    // Payload is precomputed from the next indices so the outputs come straight from flops.
    if (state_next == CFG) begin
      case (idx_next)
        2'd0: begin
          addr_next = cfg_addr_width_p'(16'h0000);
          data_next = cfg_data_width_p'(1);
        end
        2'd1: begin
          addr_next = cfg_addr_width_p'(16'h0008);
          data_next = cfg_data_width_p'(y_next) * cfg_data_width_p'(cc_x_dim_p) +
                      cfg_data_width_p'(x_next);
        end
        default: begin
          addr_next = cfg_addr_width_p'(16'h0010);
          data_next = cfg_data_width_p'({y_next, x_next});
        end
      endcase
    end
  end

  assign cfg_v_o    = issue_en;
  assign cfg_x_o    = x_reg;
  assign cfg_y_o    = y_reg;
  assign cfg_addr_o = addr_reg;
  assign cfg_data_o = data_reg;
  assign busy_o     = (state_reg == CFG) || (state_reg == FENCE) ||
                      (state_reg == UNFREEZE) || (state_reg == DRAIN);
  assign done_o     = (state_reg == DONE);
  assign err_o      = err_reg;

endmodule

// File: tb/tb_bp_cfg_sequencer.sv
// Scoreboard bench for bp_cfg_sequencer: a 2x2 instance under several ack/ready regimes
// and a 1x1 instance, each write compared against a loop-built expected sequence.
module tb_bp_cfg_sequencer;

  typedef struct packed {
    logic [0:0]  x;
    logic [0:0]  y;
    logic [15:0] addr;
    logic [63:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset_i, start_i, cfg_ready_i, ack_v_i;
  logic        cfg_v_o, busy_o, done_o, err_o;
  logic [0:0]  cfg_x_o, cfg_y_o;
  logic [15:0] cfg_addr_o;
  logic [63:0] cfg_data_o;

  logic        start1, ack1;
  logic        v1, busy1, done1, err1;
  logic [0:0]  x1, y1;
  logic [15:0] addr1;
  logic [63:0] data1;

  always #5 clk = ~clk;

  bp_cfg_sequencer #(.cc_x_dim_p(2), .cc_y_dim_p(2), .cfg_addr_width_p(16),
                     .cfg_data_width_p(64), .max_outstanding_p(4)) dut (
    .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .cfg_v_o(cfg_v_o),
    .cfg_ready_i(cfg_ready_i), .cfg_x_o(cfg_x_o), .cfg_y_o(cfg_y_o),
    .cfg_addr_o(cfg_addr_o), .cfg_data_o(cfg_data_o), .ack_v_i(ack_v_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o));

  bp_cfg_sequencer #(.cc_x_dim_p(1), .cc_y_dim_p(1), .cfg_addr_width_p(16),
                     .cfg_data_width_p(64), .max_outstanding_p(4)) dut1 (
    .clk_i(clk), .reset_i(reset_i), .start_i(start1), .cfg_v_o(v1),
    .cfg_ready_i(1'b1), .cfg_x_o(x1), .cfg_y_o(y1),
    .cfg_addr_o(addr1), .cfg_data_o(data1), .ack_v_i(ack1),
    .busy_o(busy1), .done_o(done1), .err_o(err1));

  wr_t exp_q[$];
  wr_t exp1_q[$];
  int  checks, errors;
  int  hs_total, hs1_total, hs_base, ack_owed, ack1_owed, acks_given, cnt;
  bit  auto_ack, rand_ready, held;
  wr_t held_val, cur, e;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference sequence: per-tile freeze/id/coord in raster order, then one unfreeze per tile.
  task automatic push_seq(input int nx, input int ny, input bit one);
    wr_t w;
    int  xw;
    xw = (nx > 1) ? $clog2(nx) : 1;
    for (int y = 0; y < ny; y++)
      for (int x = 0; x < nx; x++)
        for (int r = 0; r < 3; r++) begin
          w.x    = 1'(x);
          w.y    = 1'(y);
          w.addr = 16'(r * 8);
          w.data = (r == 0) ? 64'd1 : (r == 1) ? 64'(y * nx + x) : 64'((y << xw) | x);
          if (one) exp1_q.push_back(w); else exp_q.push_back(w);
        end
    for (int y = 0; y < ny; y++)
      for (int x = 0; x < nx; x++) begin
        w.x = 1'(x); w.y = 1'(y); w.addr = 16'd0; w.data = 64'd0;
        if (one) exp1_q.push_back(w); else exp_q.push_back(w);
      end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic pulse_start;
    hs_base = hs_total;
    start_i = 1'b1;
    tick(1);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (!done_o && n < budget) begin
      tick(1);
      n++;
    end
    check(name, 128'(done_o), 128'(1));
  endtask

  initial begin
    reset_i = 1'b1; start_i = 1'b0; cfg_ready_i = 1'b1; ack_v_i = 1'b0;
    start1 = 1'b0; ack1 = 1'b0;
    checks = 0; errors = 0; hs_total = 0; hs1_total = 0; hs_base = 0;
    ack_owed = 0; ack1_owed = 0; acks_given = 0;
    auto_ack = 1'b1; rand_ready = 1'b0; held = 1'b0;

    fork
      // Monitor: pops the scoreboard on every handshake and checks stall stability.
      forever begin
        @(negedge clk);
        cur = '{x: cfg_x_o, y: cfg_y_o, addr: cfg_addr_o, data: cfg_data_o};
        if (held && !reset_i)
          check("stall_hold", 128'({cfg_v_o, cur}), 128'({1'b1, held_val}));
        held = 1'b0;
        if (!reset_i && cfg_v_o) begin
          if (cfg_ready_i) begin
            hs_total++;
            if (auto_ack) ack_owed++;
            if (exp_q.size() == 0) begin
              checks++; errors++;
              $display("FAIL unexpected_write: got %0h expected none", cur);
            end else begin
              e = exp_q.pop_front();
              check("write", 128'(cur), 128'(e));
              $display("write #%0d x=%0d y=%0d addr=%h data=%0h", hs_total - hs_base,
                       cur.x, cur.y, cur.addr, cur.data);
            end
          end else begin
            held     = 1'b1;
            held_val = cur;
          end
        end
        if (!reset_i && v1) begin
          hs1_total++;
          ack1_owed++;
          cur = '{x: x1, y: y1, addr: addr1, data: data1};
          if (exp1_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_write_1x1: got %0h expected none", cur);
          end else begin
            e = exp1_q.pop_front();
            check("write_1x1", 128'(cur), 128'(e));
            $display("1x1 write #%0d addr=%h data=%0h", hs1_total, cur.addr, cur.data);
          end
        end
      end
      // Driver: one ack per cycle while owed, optional random backpressure.
      forever begin
        @(posedge clk);
        #1;
        ack_v_i = (ack_owed > 0);
        if (ack_owed > 0) ack_owed--;
        ack1 = (ack1_owed > 0);
        if (ack1_owed > 0) ack1_owed--;
        cfg_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    join_none

    tick(3);
    reset_i = 1'b0;
    tick(1);
    check("reset_busy", 128'(busy_o), 128'(0));
    check("reset_done", 128'(done_o), 128'(0));
    check("reset_err", 128'(err_o), 128'(0));
    check("reset_v", 128'(cfg_v_o), 128'(0));

    // Nominal run with one-cycle acks; CFG pass must stream one write per cycle.
    push_seq(2, 2, 1'b0);
    pulse_start();
    check("busy_after_start", 128'(busy_o), 128'(1));
    tick(12);
    check("zero_bubble", 128'(hs_total - hs_base), 128'(12));
    wait_done("done_nominal", 300);
    check("count_nominal", 128'(hs_total - hs_base), 128'(16));
    check("queue_nominal", 128'(exp_q.size()), 128'(0));
    check("busy_done", 128'(busy_o), 128'(0));
    check("err_nominal", 128'(err_o), 128'(0));

    // Credit stall, then fence with held acks.
    auto_ack = 1'b0;
    push_seq(2, 2, 1'b0);
    pulse_start();
    tick(20);
    check("credit_stall_count", 128'(hs_total - hs_base), 128'(4));
    check("credit_stall_v", 128'(cfg_v_o), 128'(0));
    ack_owed++;
    acks_given = 1;
    tick(10);
    check("one_ack_one_write", 128'(hs_total - hs_base), 128'(5));
    check("credit_stall_v2", 128'(cfg_v_o), 128'(0));
    cnt = 0;
    while ((hs_total - hs_base) < 12 && cnt < 300) begin
      if (!cfg_v_o && ack_owed == 0) begin
        ack_owed++;
        acks_given++;
      end
      tick(1);
      cnt++;
    end
    tick(10);
    check("fence_count", 128'(hs_total - hs_base), 128'(12));
    check("fence_v", 128'(cfg_v_o), 128'(0));
    check("fence_busy", 128'(busy_o), 128'(1));
    while (acks_given < 12) begin
      ack_owed++;
      acks_given++;
      tick(1);
    end
    tick(1);
    check("fence_edge_v", 128'(cfg_v_o), 128'(0));
    tick(1);
    check("unfreeze_start_v", 128'(cfg_v_o), 128'(1));
    auto_ack = 1'b1;
    wait_done("done_fence", 300);
    check("count_fence", 128'(hs_total - hs_base), 128'(16));

    // Random backpressure.
    rand_ready = 1'b1;
    push_seq(2, 2, 1'b0);
    pulse_start();
    wait_done("done_backpressure", 600);
    rand_ready = 1'b0;
    check("count_backpressure", 128'(hs_total - hs_base), 128'(16));
    check("queue_backpressure", 128'(exp_q.size()), 128'(0));

    // Reset after the 7th write; pending acks land while reset is held.
    push_seq(2, 2, 1'b0);
    pulse_start();
    cnt = 0;
    while ((hs_total - hs_base) < 7 && cnt < 100) begin
      tick(1);
      cnt++;
    end
    reset_i = 1'b1;
    tick(3);
    reset_i = 1'b0;
    exp_q.delete();
    tick(1);
    check("midreset_busy", 128'(busy_o), 128'(0));
    check("midreset_v", 128'(cfg_v_o), 128'(0));
    check("midreset_err", 128'(err_o), 128'(0));

    // Stray ack in IDLE sets sticky err; restart from IDLE keeps it, start mid-run is ignored.
    ack_owed++;
    tick(3);
    check("err_set", 128'(err_o), 128'(1));
    push_seq(2, 2, 1'b0);
    pulse_start();
    tick(3);
    start_i = 1'b1;
    tick(1);
    start_i = 1'b0;
    check("err_sticky", 128'(err_o), 128'(1));
    wait_done("done_restart", 300);
    check("count_restart", 128'(hs_total - hs_base), 128'(16));
    check("err_still", 128'(err_o), 128'(1));
    push_seq(2, 2, 1'b0);
    pulse_start();
    check("err_cleared", 128'(err_o), 128'(0));
    check("done_cleared", 128'(done_o), 128'(0));
    wait_done("done_final", 300);
    check("count_final", 128'(hs_total - hs_base), 128'(16));
    check("err_final", 128'(err_o), 128'(0));

    // 1x1 mesh.
    push_seq(1, 1, 1'b1);
    start1 = 1'b1;
    tick(1);
    start1 = 1'b0;
    cnt = 0;
    while (!done1 && cnt < 100) begin
      tick(1);
      cnt++;
    end
    check("done_1x1", 128'(done1), 128'(1));
    check("count_1x1", 128'(hs1_total), 128'(4));
    check("queue_1x1", 128'(exp1_q.size()), 128'(0));
    check("err_1x1", 128'(err1), 128'(0));
    check("busy_1x1", 128'(busy1), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
